// File: rtl/cfu_idivrem.sv
// cfu_idivrem -- iterative unsigned divide / remainder custom function unit.
//
// Responder side of the CFU request/response handshake. One request is
// accepted at a time and answered after a restoring divide that produces one
// quotient bit per cycle. Requests aimed at another interface ID, requests
// with an unknown function ID and divide-by-zero are answered one cycle after
// the accept, without iterating.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   req_valid   request present             req_ready   unit can accept
//   req_cfu     interface ID                req_func    0=DIVU, 1=REMU
//   req_id      request tag                 req_data0   dividend
//   req_data1   divisor
//   resp_valid  response present            resp_ready  initiator accepts
//   resp_id     tag of the answered request resp_err    1 = error response
//   resp_data   result, or error code (1 = unknown interface, 2 = unknown function)
//   dbg_state   current FSM state (0 IDLE, 1 FAST, 2 BUSY, 3 DONE)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. req_* is sampled only while req_ready=1; resp_* is held stable
// while resp_valid=1 and resp_ready=0.
module cfu_idivrem #(
  parameter int CFU_VERSION        = 0,
  parameter int CFU_INTERFACE_ID_W = 16,
  parameter int CFU_FUNCTION_ID_W  = 1,
  parameter int CFU_REQ_RESP_ID_W  = 6,
  parameter int CFU_REQ_DATA_W     = 32,
  parameter int CFU_RESP_DATA_W    = CFU_REQ_DATA_W,
  parameter int IID_IDIVREM        = 1001
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [CFU_INTERFACE_ID_W-1:0] req_cfu,
  input  logic [CFU_FUNCTION_ID_W-1:0]  req_func,
  input  logic [CFU_REQ_RESP_ID_W-1:0]  req_id,
  input  logic [CFU_REQ_DATA_W-1:0]     req_data0,
  input  logic [CFU_REQ_DATA_W-1:0]     req_data1,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [CFU_REQ_RESP_ID_W-1:0]  resp_id,
  output logic                          resp_err,
  output logic [CFU_RESP_DATA_W-1:0]    resp_data,
  output logic [1:0]                    dbg_state
);

  localparam int W     = CFU_REQ_DATA_W;
  localparam int IDW   = CFU_REQ_RESP_ID_W;
  localparam int CW    = $clog2(W + 1);
  localparam logic [CFU_INTERFACE_ID_W-1:0] IID = CFU_INTERFACE_ID_W'(IID_IDIVREM);
  localparam logic [CFU_FUNCTION_ID_W-1:0]  FN_MAX = CFU_FUNCTION_ID_W'(1);

  if (CFU_VERSION != 0 || CFU_RESP_DATA_W != CFU_REQ_DATA_W) begin : g_cfg_err
    $error("cfu_idivrem: only CFU_VERSION 0 with CFU_RESP_DATA_W == CFU_REQ_DATA_W is supported");
  end

  // FAST is the one-cycle path for errors and divide-by-zero.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FAST = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [W:0]      rem_q, rem_d;       // one spare bit so the shifted remainder never overflows
  logic [W-1:0]    quo_q, quo_d;       // holds the dividend at accept, the quotient at the end
  logic [W-1:0]    div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            func_q, func_d;
  logic            cfu_bad_q, cfu_bad_d;
  logic            fn_bad_q, fn_bad_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [IDW-1:0]  resp_id_q, resp_id_d;
  logic            resp_err_q, resp_err_d;
  logic [W-1:0]    resp_data_q, resp_data_d;

  // One restoring step on {rem, quo}.
  logic [W:0]      rem_sh, rem_step;
  logic [W-1:0]    quo_step;

  always_comb begin
    rem_sh   = {rem_q[W-1:0], quo_q[W-1]};
    rem_step = rem_sh;
    quo_step = {quo_q[W-2:0], 1'b0};
    if (rem_sh >= {1'b0, div_q}) begin
      rem_step    = rem_sh - {1'b0, div_q};
      quo_step[0] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    div_d       = div_q;
    cnt_d       = cnt_q;
    func_d      = func_q;
    cfu_bad_d   = cfu_bad_q;
    fn_bad_d    = fn_bad_q;
    id_d        = id_q;
    resp_id_d   = resp_id_q;
    resp_err_d  = resp_err_q;
    resp_data_d = resp_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          id_d      = req_id;
          func_d    = req_func[0];
          quo_d     = req_data0;
          rem_d     = '0;
          div_d     = req_data1;
          cnt_d     = CW'(W);
          cfu_bad_d = (req_cfu != IID);
          fn_bad_d  = (req_func > FN_MAX);
          if ((req_cfu != IID) || (req_func > FN_MAX) || (req_data1 == '0)) begin
            state_d = S_FAST;
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_FAST: begin
        resp_id_d = id_q;
        if (cfu_bad_q) begin
          resp_err_d  = 1'b1;
          resp_data_d = W'(1);
        end else if (fn_bad_q) begin
          resp_err_d  = 1'b1;
          resp_data_d = W'(2);
        end else begin
          // Divide by zero: quotient all ones, remainder is the dividend.
          resp_err_d  = 1'b0;
          resp_data_d = func_q ? quo_q : '1;
        end
        state_d = S_DONE;
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Extra cycle after the last step registers the result.
          resp_id_d   = id_q;
          resp_err_d  = 1'b0;
          resp_data_d = func_q ? rem_q[W-1:0] : quo_q;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      func_q      <= 1'b0;
      cfu_bad_q   <= 1'b0;
      fn_bad_q    <= 1'b0;
      id_q        <= '0;
      resp_id_q   <= '0;
      resp_err_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      func_q      <= func_d;
      cfu_bad_q   <= cfu_bad_d;
      fn_bad_q    <= fn_bad_d;
      id_q        <= id_d;
      resp_id_q   <= resp_id_d;
      resp_err_q  <= resp_err_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_DONE);
  assign resp_id    = resp_id_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cfu_idivrem.sv
module tb_cfu_idivrem;

  localparam int W = 32;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_cfu;
  logic [0:0]    req_func;
  logic [5:0]    req_id;
  logic [W-1:0]  req_data0;
  logic [W-1:0]  req_data1;
  logic          resp_valid;
  logic          resp_ready;
  logic [5:0]    resp_id;
  logic          resp_err;
  logic [W-1:0]  resp_data;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  // {err, data}
  logic [W:0] exp_q[$];

  cfu_idivrem dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cfu    (req_cfu),
    .req_func   (req_func),
    .req_id     (req_id),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .resp_data  (resp_data),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request with resp_ready=1, waits for the response, checks it
  // against the scoreboard and the expected latency, then checks the return to IDLE.
  task automatic run_op(input logic [15:0] cfu, input logic [0:0] func, input logic [5:0] id,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_data, input logic exp_err, input int exp_lat);
    int n;
    logic [W:0] e;
    exp_q.push_back({exp_err, exp_data});
    @(negedge clock);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_cfu    = cfu;
    req_func   = func;
    req_id     = id;
    req_data0  = a;
    req_data1  = b;
    chk("req_ready_before_accept", req_ready, 1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_data0 = $urandom;
    req_data1 = $urandom;
    req_id    = 6'($urandom_range(0, 63));
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
    e = exp_q.pop_front();
    chk("resp_data", resp_data, e[W-1:0]);
    chk("resp_err", resp_err, e[W]);
    chk("resp_id", resp_id, id);
    chk("req_ready_while_done", req_ready, 0);
    @(posedge clock);
    #1;
    chk("resp_valid_after_hs", resp_valid, 0);
    chk("req_ready_after_hs", req_ready, 1);
  endtask

  typedef struct {
    logic [15:0]  cfu;
    logic [0:0]   func;
    logic [5:0]   id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_data;
    logic         exp_err;
    int           lat;
  } vec_t;

  vec_t tbl[14];

  logic [31:0] lfsr;
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    // Galois LFSR, taps 32,22,2,1
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  initial begin
    logic [W-1:0] ra, rb, rexp;
    logic [0:0]   rf;
    logic [W-1:0] h_data;
    logic [5:0]   h_id;
    logic         h_err;
    int           n;

    //               cfu    fn   id    a             b             expected      err lat
    tbl[0]  = '{16'd1001, 1'b0, 6'd5,  32'd100,      32'd7,        32'd14,       1'b0, 33};
    tbl[1]  = '{16'd1001, 1'b1, 6'd6,  32'd100,      32'd7,        32'd2,        1'b0, 33};
    tbl[2]  = '{16'd1001, 1'b0, 6'd7,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33};
    tbl[3]  = '{16'd1001, 1'b0, 6'd8,  32'd3,        32'd10,       32'd0,        1'b0, 33};
    tbl[4]  = '{16'd1001, 1'b1, 6'd9,  32'd3,        32'd10,       32'd3,        1'b0, 33};
    tbl[5]  = '{16'd1001, 1'b0, 6'd10, 32'd9,        32'd0,        32'hFFFFFFFF, 1'b0, 1};
    tbl[6]  = '{16'd1001, 1'b1, 6'd11, 32'd9,        32'd0,        32'd9,        1'b0, 1};
    tbl[7]  = '{16'd1000, 1'b0, 6'd12, 32'd100,      32'd7,        32'd1,        1'b1, 1};
    tbl[8]  = '{16'd1001, 1'b0, 6'd13, 32'd12345678, 32'd1000,     32'd12345,    1'b0, 33};
    tbl[9]  = '{16'd1001, 1'b1, 6'd14, 32'd12345678, 32'd1000,     32'd678,      1'b0, 33};
    tbl[10] = '{16'd1001, 1'b0, 6'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        1'b0, 33};
    tbl[11] = '{16'd1001, 1'b1, 6'd16, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33};
    tbl[12] = '{16'd1001, 1'b0, 6'd17, 32'hFFFFFFFF, 32'h80000000, 32'd1,        1'b0, 33};
    tbl[13] = '{16'd1001, 1'b1, 6'd63, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1'b0, 33};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_cfu    = '0;
    req_func   = '0;
    req_id     = '0;
    req_data0  = '0;
    req_data1  = '0;
    resp_ready = 1'b1;
    lfsr       = 32'hACE1_2468;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_state", dbg_state, 0);
    @(negedge clock);
    reset = 1'b0;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 14; i++) begin
      run_op(tbl[i].cfu, tbl[i].func, tbl[i].id, tbl[i].a, tbl[i].b,
             tbl[i].exp_data, tbl[i].exp_err, tbl[i].lat);
    end
    // valid request right after an interface error: no stale state
    run_op(16'd1000, 1'b1, 6'd20, 32'd50, 32'd0, 32'd1, 1'b1, 1);
    run_op(16'd1001, 1'b1, 6'd21, 32'd50, 32'd7, 32'd1, 1'b0, 33);

    // ---------------- backpressure ----------------
    @(negedge clock);
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_cfu    = 16'd1001;
    req_func   = 1'b0;
    req_id     = 6'd33;
    req_data0  = 32'd1000;
    req_data1  = 32'd9;
    @(posedge clock);
    #1;
    // a different request stays presented for the whole wait
    req_id    = 6'd44;
    req_data0 = 32'd77;
    req_data1 = 32'd0;
    n = 0;
    while (!resp_valid && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("bp_latency", 64'(n), 33);
    h_data = resp_data;
    h_id   = resp_id;
    h_err  = resp_err;
    chk("bp_data", resp_data, 32'd111);
    chk("bp_id", resp_id, 6'd33);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      chk("bp_valid_held", resp_valid, 1);
      chk("bp_data_stable", resp_data, h_data);
      chk("bp_id_stable", resp_id, h_id);
      chk("bp_err_stable", resp_err, h_err);
      chk("bp_req_ready", req_ready, 0);
    end
    @(negedge clock);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    chk("bp_valid_after_hs", resp_valid, 0);
    chk("bp_ready_after_hs", req_ready, 1);
    repeat (3) @(posedge clock);
    #1;
    chk("bp_no_extra_resp", resp_valid, 0);
    chk("bp_no_extra_accept", req_ready, 1);

    // ---------------- reset mid-operation ----------------
    @(negedge clock);
    req_valid = 1'b1;
    req_cfu   = 16'd1001;
    req_func  = 1'b0;
    req_id    = 6'd50;
    req_data0 = 32'd5000;
    req_data1 = 32'd3;
    @(posedge clock);                       // edge 0
    #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clock);            // edge 9
    @(negedge clock);
    chk("mid_busy_state", dbg_state, 2);
    reset = 1'b1;
    @(posedge clock);                       // edge 10
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_resp_id", resp_id, 0);
    chk("mid_rst_resp_err", resp_err, 0);
    chk("mid_rst_resp_data", resp_data, 0);
    @(negedge clock);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (resp_valid) n++;
    end
    chk("mid_rst_no_resp", 64'(n), 0);
    run_op(16'd1001, 1'b0, 6'd51, 32'd1000, 32'd10, 32'd100, 1'b0, 33);

    // ---------------- LFSR-driven operands against a / and % model ----------------
    for (int i = 0; i < 500; i++) begin
      lfsr = lfsr_next(lfsr);
      ra   = lfsr;
      lfsr = lfsr_next(lfsr);
      rb   = lfsr >> (lfsr[4:0]);
      lfsr = lfsr_next(lfsr);
      rf   = lfsr[0];
      if (rb == 0) rexp = rf ? ra : 32'hFFFFFFFF;
      else         rexp = rf ? (ra % rb) : (ra / rb);
      run_op(16'd1001, rf, 6'(i), ra, rb, rexp, 1'b0, (rb == 0) ? 1 : 33);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
